// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder datapath: FSM encoding and default width.
// Latency: none (package only).
// Backpressure: none (package only).
package adder_pkg;

   localparam int ADDER_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR for the carry.
// Latency: combinational.
// Backpressure: none.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a     (a),
      .b     (b),
      .sum   (s0),
      .carry (c0)
   );

   half_adder u_ha1 (
      .a     (s0),
      .b     (cin),
      .sum   (sum),
      .carry (c1)
   );

   // both half-adder carries can never be 1 at once, so OR gives the majority
   always_comb begin
      cout = c0 | c1;
   end

endmodule

// File: rtl/half_adder.sv
// One-bit half adder, the leaf arithmetic cell.
// Latency: combinational.
// Backpressure: none.
module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   // sum is the XOR of the inputs, carry is their AND
   always_comb begin
      sum   = a ^ b;
      carry = a & b;
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit pair per clock; macro SERIAL_ADDER_CIN_EN adds a cin port.
// Latency: done pulses WIDTH cycles after the accepting edge; back-to-back period is WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests in RUN/DONE are dropped, never queued.
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADDER_CIN_EN
   input  logic             cin,
`endif
   output logic             busy,
   output logic             done,
   output logic             sum_bit,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             last_bit;

   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             carry_init;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             fa_sum;
   logic             fa_cout;

`ifdef SERIAL_ADDER_CIN_EN
   assign carry_init = cin;
`else
   assign carry_init = 1'b0;
`endif

   full_adder_cell u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // sum register shifts right with the new bit entering at the MSB
   always_comb begin
      sum_nxt = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode and handshake outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      last_bit  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST_CNT) begin
               last_bit  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // datapath: load on accept, one full-adder step per RUN edge, publish on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         sum_bit   <= 1'b0;
         sum_out   <= '0;
         carry_out <= 1'b0;
      end else if (accept) begin
         a_sh  <= a_in;
         b_sh  <= b_in;
         carry <= carry_init;
         cnt   <= '0;
      end else if (state == RUN) begin
         carry   <= fa_cout;
         sum_bit <= fa_sum;
         sum_sh  <= sum_nxt;
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         if (last_bit) begin
            // counter stops at WIDTH-1 so it never leaves its legal range
            sum_out   <= sum_nxt;
            carry_out <= fa_cout;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
